an_rx_detect: RTL and testbench

- Receive-side monitor for the AN range tone transmitter.
- Consumes the two 1-bit delta-sigma streams (DS_L, DS_R) the transmitter produces.
- Decimates each stream to PCM with a boxcar filter, measures per-channel tone envelope over fixed frames, and thresholds each envelope.
- A debounced state machine recovers which channel carries the tone (the LXR keying state) for loopback verification and on-board self-test.

---
 rtl/an_rx_detect.sv | 110 +++++++++++
 tb/tb_an_rx_detect.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/an_rx_detect.sv
// an_rx_detect: recovers the AN range-tone keying state from the two delta-sigma streams
module an_rx_detect #(
  parameter int C_DEC_N = 64,
  parameter int C_ENV_N = 256,
  parameter int C_THR = 4096,
  parameter int C_DEB = 2,
  localparam int EW = $clog2(C_ENV_N * C_DEC_N / 2 + 1)
) (
  input  logic          CK_i,
  input  logic          RST_i,
  input  logic          DS_L_i,
  input  logic          DS_R_i,
  output logic [EW-1:0] L_ENVs_o,
  output logic [EW-1:0] R_ENVs_o,
  output logic          FRAME_EE_o,
  output logic          L_ON_o,
  output logic          R_ON_o,
  output logic          LXR_o,
  output logic          LXR_VALID_o
);
  localparam int DW = $clog2(C_DEC_N);
  localparam int OW = $clog2(C_DEC_N + 1);
  localparam int VW = C_ENV_N > 1 ? $clog2(C_ENV_N) : 1;
  localparam int CW = $clog2(C_DEB + 1);
  localparam logic [OW-1:0] HALF = OW'(C_DEC_N / 2);
  typedef enum logic [1:0] {S_NONE = 2'b00, S_R = 2'b01, S_L = 2'b10, S_BOTH = 2'b11} state_t;
  function automatic logic [OW-1:0] dev_of(input logic [OW-1:0] s);
    return s >= HALF ? s - HALF : HALF - s;
  endfunction
  logic [DW-1:0] dec_ctr;
  logic [OW-1:0] l_ones, r_ones, l_samp, r_samp, l_cnt, r_cnt;
  logic          samp_vld, wrap, last, upd;
  logic [VW-1:0] env_ctr;
  logic [EW-1:0] l_acc, r_acc, l_sum, r_sum;
  state_t        state, cand, cls;
  logic [CW-1:0] cnt;
  assign wrap  = dec_ctr == DW'(C_DEC_N - 1);
  assign last  = env_ctr == VW'(C_ENV_N - 1);
  assign l_cnt = l_ones + OW'(DS_L_i);
  assign r_cnt = r_ones + OW'(DS_R_i);
  assign l_sum = l_acc + EW'(dev_of(l_samp));
  assign r_sum = r_acc + EW'(dev_of(r_samp));
  assign cls   = state_t'({L_ON_o, R_ON_o});
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      dec_ctr  <= '0;
      l_ones   <= '0;
      r_ones   <= '0;
      l_samp   <= '0;
      r_samp   <= '0;
      samp_vld <= 1'b0;
    end else begin
      dec_ctr  <= wrap ? '0 : dec_ctr + DW'(1);
      l_ones   <= wrap ? '0 : l_cnt;
      r_ones   <= wrap ? '0 : r_cnt;
      samp_vld <= wrap;
      if (wrap) begin
        l_samp <= l_cnt;
        r_samp <= r_cnt;
      end
    end
  end
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      env_ctr    <= '0;
      l_acc      <= '0;
      r_acc      <= '0;
      L_ENVs_o   <= '0;
      R_ENVs_o   <= '0;
      L_ON_o     <= 1'b0;
      R_ON_o     <= 1'b0;
      FRAME_EE_o <= 1'b0;
    end else begin
      FRAME_EE_o <= samp_vld && last;
      if (samp_vld) begin
        env_ctr <= last ? '0 : env_ctr + VW'(1);
        l_acc   <= last ? '0 : l_sum;
        r_acc   <= last ? '0 : r_sum;
        if (last) begin
          L_ENVs_o <= l_sum;
          R_ENVs_o <= r_sum;
          L_ON_o   <= int'(l_sum) >= C_THR;
          R_ON_o   <= int'(r_sum) >= C_THR;
        end
      end
    end
  end
  // candidate/count update on the FRAME_EE cycle, state commit one cycle later
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      state       <= S_NONE;
      cand        <= S_NONE;
      cnt         <= '0;
      upd         <= 1'b0;
      LXR_o       <= 1'b0;
      LXR_VALID_o <= 1'b0;
    end else begin
      upd <= FRAME_EE_o;
      if (FRAME_EE_o) begin
        cand <= cls;
        cnt  <= cls != cand ? CW'(1) : cnt == CW'(C_DEB) ? cnt : cnt + CW'(1);
      end
      if (upd && cnt == CW'(C_DEB) && state != cand) begin
        state       <= cand;
        LXR_VALID_o <= cand == S_L || cand == S_R;
        LXR_o       <= cand == S_R ? 1'b1 : cand == S_L ? 1'b0 : LXR_o;
      end
    end
  end
endmodule

// File: tb/tb_an_rx_detect.sv
// tb_an_rx_detect: default-size latency/boundary run plus table-driven frames on small instances
module tb_an_rx_detect;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic b_rst = 1'b1, b_dl = 1'b0, b_dr = 1'b0;
  logic [13:0] b_lenv, b_renv;
  logic b_fee, b_lon, b_ron, b_lxr, b_vld;
  logic s_rst = 1'b1, s_dl = 1'b0, s_dr = 1'b0;
  logic [4:0] s_lenv, s_renv, d_lenv, d_renv;
  logic s_fee, s_lon, s_ron, s_lxr, s_vld;
  logic d_fee, d_lon, d_ron, d_lxr, d_vld;
  an_rx_detect big (.CK_i(clk), .RST_i(b_rst), .DS_L_i(b_dl), .DS_R_i(b_dr),
    .L_ENVs_o(b_lenv), .R_ENVs_o(b_renv), .FRAME_EE_o(b_fee), .L_ON_o(b_lon),
    .R_ON_o(b_ron), .LXR_o(b_lxr), .LXR_VALID_o(b_vld));
  an_rx_detect #(.C_DEC_N(8), .C_ENV_N(4), .C_THR(8), .C_DEB(2)) sm (.CK_i(clk), .RST_i(s_rst),
    .DS_L_i(s_dl), .DS_R_i(s_dr), .L_ENVs_o(s_lenv), .R_ENVs_o(s_renv), .FRAME_EE_o(s_fee),
    .L_ON_o(s_lon), .R_ON_o(s_ron), .LXR_o(s_lxr), .LXR_VALID_o(s_vld));
  an_rx_detect #(.C_DEC_N(8), .C_ENV_N(4), .C_THR(8), .C_DEB(1)) d1 (.CK_i(clk), .RST_i(s_rst),
    .DS_L_i(s_dl), .DS_R_i(s_dr), .L_ENVs_o(d_lenv), .R_ENVs_o(d_renv), .FRAME_EE_o(d_fee),
    .L_ON_o(d_lon), .R_ON_o(d_ron), .LXR_o(d_lxr), .LXR_VALID_o(d_vld));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic logic pat(input int w, input int pos);
    return w == 4 ? pos[0] : (pos % 8) < w;
  endfunction
  typedef struct {
    int wl, wr, le, re, lon, ron, lxr, vld, dlxr, dvld;
  } vec_t;
  vec_t tbl[19];
  initial begin
    int n, nfee, lxr_at, exp_lxr, exp_vld;
    bit done;
    tbl[0]  = '{4, 4,  0,  0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{8, 4, 16,  0, 1, 0, 0, 0, 0, 1};
    tbl[2]  = '{8, 4, 16,  0, 1, 0, 0, 1, 0, 1};
    tbl[3]  = '{4, 0,  0, 16, 0, 1, 0, 1, 1, 1};
    tbl[4]  = '{4, 0,  0, 16, 0, 1, 1, 1, 1, 1};
    tbl[5]  = '{4, 4,  0,  0, 0, 0, 1, 1, 1, 0};
    tbl[6]  = '{4, 4,  0,  0, 0, 0, 1, 0, 1, 0};
    tbl[7]  = '{6, 4,  8,  0, 1, 0, 1, 0, 0, 1};
    tbl[8]  = '{5, 4,  4,  0, 0, 0, 1, 0, 0, 0};
    tbl[9]  = '{8, 4, 16,  0, 1, 0, 1, 0, 0, 1};
    tbl[10] = '{4, 8,  0, 16, 0, 1, 1, 0, 1, 1};
    tbl[11] = '{8, 4, 16,  0, 1, 0, 1, 0, 0, 1};
    tbl[12] = '{0, 8, 16, 16, 1, 1, 1, 0, 0, 0};
    tbl[13] = '{0, 8, 16, 16, 1, 1, 1, 0, 0, 0};
    tbl[14] = '{2, 7,  8, 12, 1, 1, 1, 0, 0, 0};
    tbl[15] = '{4, 0,  0, 16, 0, 1, 1, 0, 1, 1};
    tbl[16] = '{4, 0,  0, 16, 0, 1, 1, 1, 1, 1};
    tbl[17] = '{4, 0,  0, 16, 0, 1, 1, 1, 1, 1};
    tbl[18] = '{8, 8,  0,  0, 0, 0, 0, 0, 0, 0};
    repeat (5) begin
      @(negedge clk);
      b_dl = 1'($urandom);
      b_dr = 1'($urandom);
    end
    @(negedge clk);
    chk("b_rst_lenv", b_lenv, 0);
    chk("b_rst_renv", b_renv, 0);
    chk("b_rst_fee", b_fee, 0);
    chk("b_rst_lon", b_lon, 0);
    chk("b_rst_ron", b_ron, 0);
    chk("b_rst_lxr", b_lxr, 0);
    chk("b_rst_vld", b_vld, 0);
    b_rst = 1'b0;
    n = 1;
    nfee = 0;
    lxr_at = -1;
    done = 0;
    while (!done && n <= 40000) begin
      b_dl = n - 1 < 16384 ? ((n - 1) % 64) < 48 : 1'b1;
      b_dr = 1'((n - 1) % 2);
      if (b_fee) begin
        nfee++;
        chk(nfee == 1 ? "b_fee1_clk" : "b_fee2_clk", n, nfee == 1 ? 16386 : 32770);
        chk("b_lenv", b_lenv, nfee == 1 ? 4096 : 8192);
        chk("b_renv", b_renv, 0);
        chk("b_lon", b_lon, 1);
        chk("b_ron", b_ron, 0);
        lxr_at = n + 2;
      end
      if (n == lxr_at) begin
        chk("b_lxr", b_lxr, 0);
        chk("b_vld", b_vld, nfee == 2 ? 1 : 0);
        done = nfee >= 2;
      end
      @(negedge clk);
      n++;
    end
    chk("b_done", done, 1);
    @(negedge clk);
    chk("s_rst_lenv", s_lenv, 0);
    chk("s_rst_vld", s_vld, 0);
    s_rst = 1'b0;
    for (int i = 0; i < 19; i++) begin
      for (int j = 0; j < 32; j++) begin
        if (i == 18 && j == 12) break;
        s_dl = pat(tbl[i].wl, 32 * i + j);
        s_dr = pat(tbl[i].wr, 32 * i + j);
        chk("s_fee", s_fee, i > 0 && j == 1);
        chk("d_fee", d_fee, i > 0 && j == 1);
        if (i > 0 && j == 1) begin
          chk("s_lenv", s_lenv, tbl[i-1].le);
          chk("s_renv", s_renv, tbl[i-1].re);
          chk("s_lon", s_lon, tbl[i-1].lon);
          chk("s_ron", s_ron, tbl[i-1].ron);
          chk("d_lenv", d_lenv, tbl[i-1].le);
          chk("d_ron", d_ron, tbl[i-1].ron);
        end
        if (i > 0 && j == 3) begin
          chk("s_lxr", s_lxr, tbl[i-1].lxr);
          chk("s_vld", s_vld, tbl[i-1].vld);
          chk("d_lxr", d_lxr, tbl[i-1].dlxr);
          chk("d_vld", d_vld, tbl[i-1].dvld);
        end
        @(negedge clk);
      end
    end
    s_rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("s_rst_fee", s_fee, 0);
    end
    chk("s_mid_lenv", s_lenv, 0);
    chk("s_mid_renv", s_renv, 0);
    chk("s_mid_lon", s_lon, 0);
    chk("s_mid_ron", s_ron, 0);
    chk("s_mid_lxr", s_lxr, 0);
    chk("s_mid_vld", s_vld, 0);
    chk("d_mid_lxr", d_lxr, 0);
    chk("d_mid_vld", d_vld, 0);
    s_rst = 1'b0;
    n = 1;
    done = 0;
    while (!done && n <= 200) begin
      s_dl = 1'((n - 1) % 2);
      s_dr = 1'(n % 2);
      if (s_fee) begin
        chk("s_mid_fee_clk", n, 34);
        chk("s_mid_env_l", s_lenv, 0);
        chk("s_mid_env_r", s_renv, 0);
        done = 1;
      end
      @(negedge clk);
      n++;
    end
    chk("s_mid_done", done, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
